// File: rtl/stream_mux_pkg.sv
// Package: stream_mux_pkg
// Shared helpers for the N:1 registered stream multiplexer.
// - MAX_N / MAX_IDX_W : upper bound on channel count handled by rr_pick
//                       and the matching index width.
// - rr_pick           : round-robin search over a request vector, starting
//                       at ptr and wrapping n-1 -> 0; returns the found flag
//                       and writes the winner index to idx.
package stream_mux_pkg;

   localparam int unsigned MAX_N     = 32;
   localparam int unsigned MAX_IDX_W = $clog2(MAX_N);

   // ptr must be < n and n <= MAX_N. The first requester at or after ptr
   // (in wrapped ascending order) wins.
   function automatic logic rr_pick(input  logic [MAX_N-1:0] valid,
                                    input  int unsigned      ptr,
                                    input  int unsigned      n,
                                    output int unsigned      idx);
      int unsigned c;
      rr_pick = 1'b0;
      idx     = 0;
      for (int unsigned k = 0; k < MAX_N; k++) begin
         c = ptr + k;
         if (c >= n) c = c - n;
         if ((k < n) && !rr_pick && (|(valid & (MAX_N'(1) << c)))) begin
            rr_pick = 1'b1;
            idx     = c;
         end
      end
   endfunction

endpackage

// File: rtl/stream_mux_nx1_arb.sv
// Module: rr_arbiter
// Purely combinational round-robin arbiter for stream_mux_nx1.
// Ports:
//   req        in  N      request vector (one bit per channel)
//   ptr        in  IDX_W  channel with highest priority this cycle
//   lock_en    in  1      (STREAM_MUX_PKT_LOCK_EN only) restrict grant to lock_idx
//   lock_idx   in  IDX_W  (STREAM_MUX_PKT_LOCK_EN only) channel owning the packet
//   gnt_onehot out N      one-hot grant, zero when nothing is granted
//   gnt_idx    out IDX_W  index of the granted channel
//   gnt_any    out 1      a grant was issued
// Optional feature macro: STREAM_MUX_PKT_LOCK_EN.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int unsigned N     = 4,
   localparam int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
`ifdef STREAM_MUX_PKT_LOCK_EN
   input  logic             lock_en,
   input  logic [IDX_W-1:0] lock_idx,
`endif
   output logic [N-1:0]     gnt_onehot,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_any
);

   logic        rr_found;
   int unsigned rr_idx;

   always_comb begin
      rr_idx   = 0;
      rr_found = rr_pick(MAX_N'(req), 32'(ptr), N, rr_idx);
`ifdef STREAM_MUX_PKT_LOCK_EN
      // A locked packet owns the port even while its source is idle.
      if (lock_en) begin
         gnt_any = req[lock_idx];
         gnt_idx = lock_idx;
      end else begin
         gnt_any = rr_found;
         gnt_idx = IDX_W'(rr_idx);
      end
`else
      gnt_any = rr_found;
      gnt_idx = IDX_W'(rr_idx);
`endif
      gnt_onehot = gnt_any ? (N'(1) << gnt_idx) : '0;
   end

endmodule

// File: rtl/stream_mux_nx1.sv
// Module: stream_mux_nx1
// N-input, W-bit stream multiplexer with valid/ready handshakes, round-robin
// arbitration and one registered output stage (no skid buffer: m_ready
// reaches s_ready combinationally).
// Ports:
//   clk      in   1          rising-edge clock
//   reset    in   1          synchronous, active-high reset
//   s_valid  in   N          per-channel valid
//   s_data   in   N*W        channel i at [i*W +: W]
//   s_ready  out  N          per-channel ready, at most one bit high
//   m_valid  out  1          registered output valid
//   m_data   out  W          registered output data
//   m_ready  in   1          downstream ready
//   m_src    out  IDX_W      channel that produced m_data
//   s_last   in   N          (STREAM_MUX_PKT_LOCK_EN only) end-of-packet per channel
//   m_last   out  1          (STREAM_MUX_PKT_LOCK_EN only) registered end-of-packet
// Optional feature macro: STREAM_MUX_PKT_LOCK_EN (packet lock on s_last).
module stream_mux_nx1
   import stream_mux_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned W     = 8,
   localparam int unsigned IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     s_valid,
   input  logic [N*W-1:0]   s_data,
   output logic [N-1:0]     s_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
   input  logic [N-1:0]     s_last,
   output logic             m_last,
`endif
   output logic             m_valid,
   output logic [W-1:0]     m_data,
   input  logic             m_ready,
   output logic [IDX_W-1:0] m_src
);

   logic             m_valid_q, m_valid_d;
   logic [W-1:0]     m_data_q,  m_data_d;
   logic [IDX_W-1:0] m_src_q,   m_src_d;
   logic [IDX_W-1:0] rr_ptr_q,  rr_ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
   logic             m_last_q,   m_last_d;
   logic             lock_q,     lock_d;
   logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
`endif

   logic [N-1:0]     gnt_onehot;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_any;
   logic             load;
   logic             xfer;
   logic [IDX_W-1:0] gnt_next;

   rr_arbiter #(.N(N)) u_arb (
      .req        (s_valid),
      .ptr        (rr_ptr_q),
`ifdef STREAM_MUX_PKT_LOCK_EN
      .lock_en    (lock_q),
      .lock_idx   (lock_idx_q),
`endif
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .gnt_any    (gnt_any)
   );

   always_comb begin
      // The output register can take a beat when empty or draining this edge.
      load    = ~m_valid_q | m_ready;
      // Gating with reset keeps sources from seeing a handshake that the
      // reset would then discard.
      xfer    = ~reset & load & gnt_any;
      s_ready = xfer ? gnt_onehot : '0;

      gnt_next = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);

      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_src_d   = m_src_q;
      rr_ptr_d  = rr_ptr_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
      m_last_d   = m_last_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
`endif

      if (load) m_valid_d = xfer;
      if (xfer) begin
         m_data_d = s_data[32'(gnt_idx) * W +: W];
         m_src_d  = gnt_idx;
         rr_ptr_d = gnt_next;
`ifdef STREAM_MUX_PKT_LOCK_EN
         m_last_d = s_last[gnt_idx];
         // A non-final beat pins the arbiter to this channel; the final
         // beat releases it with rr_ptr already pointing past the owner.
         lock_d     = ~s_last[gnt_idx];
         lock_idx_d = gnt_idx;
`else
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         m_src_q    <= '0;
         rr_ptr_q   <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
         m_last_q   <= 1'b0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
`endif
      end else begin
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
         m_src_q    <= m_src_d;
         rr_ptr_q   <= rr_ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
         m_last_q   <= m_last_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
`endif
      end
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_src   = m_src_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
   assign m_last  = m_last_q;
`endif

endmodule
